// File: rtl/pc_redirect_unit_pkg.sv
// Shared encodings for the PC redirect unit: branch/jump decision codes,
// controller states and the sequential fetch step.
package pc_redirect_unit_pkg;

  typedef enum logic [1:0] {
    BAJ_NONE = 2'b00,
    BAJ_BRJ  = 2'b01,
    BAJ_JR   = 2'b10,
    BAJ_ILL  = 2'b11
  } baj_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic is_request(input logic [1:0] baj);
    return (baj == BAJ_BRJ) || (baj == BAJ_JR);
  endfunction

endpackage

// File: rtl/pc_redirect_unit_target_calc.sv
// Combinational redirect target: PC-relative branch, pseudo-direct j, or jr
// with the low two bits forced to word alignment.
module redirect_target_calc
  import pc_redirect_unit_pkg::*;
(
  input  logic [1:0]  BranchAndJump,
  input  logic        IsJump,
  input  logic [31:0] DecodePC,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] RegTarget,
  output logic [31:0] target
);

  logic        [31:0] pc_plus4;
  logic signed [31:0] offset_bytes;
  logic               unused_reg_low;

  assign pc_plus4       = DecodePC + PC_STEP;
  assign offset_bytes   = signed'(BranchOffset) <<< 2;
  assign unused_reg_low = ^RegTarget[1:0];

  always_comb begin
    target = pc_plus4;
    case (BranchAndJump)
      BAJ_BRJ: begin
        if (IsJump) target = {pc_plus4[31:28], JumpIndex, 2'b00};
        else        target = pc_plus4 + $unsigned(offset_bytes);
      end
      BAJ_JR:  target = {RegTarget[31:2], 2'b00};
      default: target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: advances sequentially, redirects on taken
// branch/j/jr, defers a redirect across stalls and flushes the wrong path.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
)(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [1:0]  BranchAndJump,
  input  logic        IsJump,
  input  logic [31:0] DecodePC,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] RegTarget,
  output logic [31:0] PC,
  output logic        Flush,
  output logic        Redirect,
  output logic        Pending,
  output logic        IllegalReq
);

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_e      state;
  logic [31:0] target;
  logic [31:0] pend_target;
  logic [1:0]  cnt;
  logic        request;

  redirect_target_calc u_target (
    .BranchAndJump (BranchAndJump),
    .IsJump        (IsJump),
    .DecodePC      (DecodePC),
    .BranchOffset  (BranchOffset),
    .JumpIndex     (JumpIndex),
    .RegTarget     (RegTarget),
    .target        (target)
  );

  assign request = is_request(BranchAndJump);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_RUN;
      PC          <= RESET_PC;
      Flush       <= 1'b0;
      Redirect    <= 1'b0;
      Pending     <= 1'b0;
      IllegalReq  <= 1'b0;
      pend_target <= '0;
      cnt         <= '0;
    end else begin
      Redirect   <= 1'b0;
      IllegalReq <= 1'b0;
      case (state)
        ST_RUN: begin
          IllegalReq <= (BranchAndJump == BAJ_ILL);
          if (request) begin
            if (!Stall) begin
              PC       <= target;
              Redirect <= 1'b1;
              Flush    <= 1'b1;
              cnt      <= CNT_INIT;
              state    <= ST_FLUSH;
            end else begin
              pend_target <= target;
              Pending     <= 1'b1;
              state       <= ST_HOLD;
            end
          end else if (!Stall) begin
            PC <= PC + PC_STEP;
          end
        end
        // The captured target is the only redirect honoured until it lands.
        ST_HOLD: begin
          if (!Stall) begin
            PC       <= pend_target;
            Redirect <= 1'b1;
            Flush    <= 1'b1;
            Pending  <= 1'b0;
            cnt      <= CNT_INIT;
            state    <= ST_FLUSH;
          end
        end
        // Requests seen here come from squashed instructions and are dropped.
        ST_FLUSH: begin
          if (!Stall) begin
            PC <= PC + PC_STEP;
            if (cnt == 2'd0) begin
              Flush <= 1'b0;
              state <= ST_RUN;
            end else begin
              cnt <= cnt - 2'd1;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: two instances (FLUSH_CYCLES 1 and 2) on shared
// stimulus, each compared against a behavioural model, plus directed checks.
module tb_pc_redirect_unit;

  logic        Clk = 1'b0;
  logic        Reset, Stall, IsJump;
  logic [1:0]  BranchAndJump;
  logic [31:0] DecodePC, BranchOffset, RegTarget;
  logic [25:0] JumpIndex;

  logic [31:0] pc1, pc2;
  logic        flush1, redir1, pend1, ill1;
  logic        flush2, redir2, pend2, ill2;
  logic [35:0] obs1, obs2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  pc_redirect_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchAndJump(BranchAndJump),
    .IsJump(IsJump), .DecodePC(DecodePC), .BranchOffset(BranchOffset),
    .JumpIndex(JumpIndex), .RegTarget(RegTarget), .PC(pc1), .Flush(flush1),
    .Redirect(redir1), .Pending(pend1), .IllegalReq(ill1));

  pc_redirect_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchAndJump(BranchAndJump),
    .IsJump(IsJump), .DecodePC(DecodePC), .BranchOffset(BranchOffset),
    .JumpIndex(JumpIndex), .RegTarget(RegTarget), .PC(pc2), .Flush(flush2),
    .Redirect(redir2), .Pending(pend2), .IllegalReq(ill2));

  assign obs1 = {pc1, flush1, redir1, pend1, ill1};
  assign obs2 = {pc2, flush2, redir2, pend2, ill2};

  // Model: flush_left counts remaining non-stalled flush cycles.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ptarget;
    logic [3:0]  flush_left;
    logic        pending;
    logic        redirect;
    logic        illegal;
  } mdl_t;

  mdl_t m1, m2;

  function automatic logic [31:0] exp_target();
    logic [31:0] p4;
    p4 = DecodePC + 32'd4;
    if (BranchAndJump == 2'd2) return RegTarget & 32'hFFFF_FFFC;
    if (IsJump) return {p4[31:28], JumpIndex, 2'b00};
    return p4 + BranchOffset * 32'd4;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int f);
    mdl_t n;
    logic req;
    n = m;
    n.redirect = 1'b0;
    n.illegal  = 1'b0;
    req = (BranchAndJump == 2'd1) || (BranchAndJump == 2'd2);
    if (Reset) begin
      n = '0;
    end else if (m.flush_left != 0) begin
      if (!Stall) begin
        n.pc = m.pc + 32'd4;
        n.flush_left = m.flush_left - 4'd1;
      end
    end else if (m.pending) begin
      if (!Stall) begin
        n.pc = m.ptarget;
        n.redirect = 1'b1;
        n.pending = 1'b0;
        n.flush_left = 4'(f);
      end
    end else begin
      n.illegal = (BranchAndJump == 2'd3);
      if (req && !Stall) begin
        n.pc = exp_target();
        n.redirect = 1'b1;
        n.flush_left = 4'(f);
      end else if (req) begin
        n.pending = 1'b1;
        n.ptarget = exp_target();
      end else if (!Stall) begin
        n.pc = m.pc + 32'd4;
      end
    end
    return n;
  endfunction

  function automatic logic [35:0] expv(input mdl_t m);
    return {m.pc, (m.flush_left != 0), m.redirect, m.pending, m.illegal};
  endfunction

  task automatic tick();
    @(posedge Clk);
    m1 = step(m1, 1);
    m2 = step(m2, 2);
    #1;
  endtask

  task automatic set_idle();
    Reset = 1'b0; Stall = 1'b0; BranchAndJump = 2'd0; IsJump = 1'b0;
    DecodePC = '0; BranchOffset = '0; JumpIndex = '0; RegTarget = '0;
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) begin
      tick();
      n_checks += 2;
      if (obs1 !== expv(m1)) begin n_fail++; $display("FAIL idle dut1 got=%h exp=%h", obs1, expv(m1)); end
      if (obs2 !== expv(m2)) begin n_fail++; $display("FAIL idle dut2 got=%h exp=%h", obs2, expv(m2)); end
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    set_idle();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      n_checks += 2;
      if (obs1 !== {exp_pc[i], 4'b0000}) begin n_fail++; $display("FAIL reset_seq%0d dut1 got=%h exp=%h", i, obs1, {exp_pc[i], 4'b0000}); end
      if (obs2 !== {exp_pc[i], 4'b0000}) begin n_fail++; $display("FAIL reset_seq%0d dut2 got=%h exp=%h", i, obs2, {exp_pc[i], 4'b0000}); end
    end
  endtask

  task automatic test_branch();
    set_idle();
    BranchAndJump = 2'd1; DecodePC = 32'h100; BranchOffset = 32'd3;
    tick();
    n_checks++;
    if ({pc1, flush1, redir1} !== {32'h110, 2'b11}) begin n_fail++; $display("FAIL branch_fwd got=%h exp=%h", {pc1, flush1, redir1}, {32'h110, 2'b11}); end
    set_idle();
    tick();
    n_checks++;
    if ({pc1, flush1, redir1} !== {32'h114, 2'b00}) begin n_fail++; $display("FAIL branch_after got=%h exp=%h", {pc1, flush1, redir1}, {32'h114, 2'b00}); end
    idle(2);
    BranchAndJump = 2'd1; DecodePC = 32'h200; BranchOffset = 32'hFFFF_FFFE;
    tick();
    n_checks += 2;
    if (pc1 !== 32'h1FC) begin n_fail++; $display("FAIL branch_back dut1 got=%h exp=%h", pc1, 32'h1FC); end
    if (pc2 !== 32'h1FC) begin n_fail++; $display("FAIL branch_back dut2 got=%h exp=%h", pc2, 32'h1FC); end
    idle(3);
  endtask

  task automatic test_jumps();
    logic [31:0] prev;
    set_idle();
    BranchAndJump = 2'd1; IsJump = 1'b1; DecodePC = 32'hA000_0100; JumpIndex = 26'h200;
    tick();
    n_checks++;
    if ({pc1, redir1} !== {32'hA000_0800, 1'b1}) begin n_fail++; $display("FAIL jump_j got=%h exp=%h", {pc1, redir1}, {32'hA000_0800, 1'b1}); end
    idle(3);
    BranchAndJump = 2'd2; RegTarget = 32'h0000_1237;
    tick();
    n_checks++;
    if ({pc2, redir2} !== {32'h1234, 1'b1}) begin n_fail++; $display("FAIL jump_jr got=%h exp=%h", {pc2, redir2}, {32'h1234, 1'b1}); end
    idle(3);
    prev = pc1;
    BranchAndJump = 2'd3;
    tick();
    n_checks++;
    if ({pc1, ill1, redir1, flush1} !== {prev + 32'd4, 3'b100}) begin n_fail++; $display("FAIL illegal got=%h exp=%h", {pc1, ill1, redir1, flush1}, {prev + 32'd4, 3'b100}); end
    idle(1);
    n_checks++;
    if (ill1 !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got=%b exp=0", ill1); end
    idle(1);
  endtask

  task automatic test_stall_redirect();
    logic [31:0] frozen;
    set_idle();
    frozen = pc1;
    Stall = 1'b1; BranchAndJump = 2'd1; DecodePC = 32'h300; BranchOffset = 32'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({pc1, pend1, redir1} !== {frozen, 2'b10}) begin n_fail++; $display("FAIL hold%0d got=%h exp=%h", i, {pc1, pend1, redir1}, {frozen, 2'b10}); end
      BranchAndJump = 2'd2; RegTarget = 32'h0000_9000;
    end
    set_idle();
    tick();
    n_checks += 2;
    if ({pc1, pend1, redir1, flush1} !== {32'h318, 3'b011}) begin n_fail++; $display("FAIL hold_release dut1 got=%h exp=%h", {pc1, pend1, redir1, flush1}, {32'h318, 3'b011}); end
    if (obs2 !== expv(m2)) begin n_fail++; $display("FAIL hold_release dut2 got=%h exp=%h", obs2, expv(m2)); end
    idle(3);
  endtask

  task automatic test_flush_stall();
    // Per tick: stall, then dut2 {PC, Flush} expected after the edge.
    logic        stl [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [32:0] exp2 [5] = '{{32'h404, 1'b1}, {32'h404, 1'b1}, {32'h404, 1'b1},
                              {32'h408, 1'b1}, {32'h40C, 1'b0}};
    set_idle();
    BranchAndJump = 2'd1; DecodePC = 32'h400; BranchOffset = 32'd0;
    for (int i = 0; i < 5; i++) begin
      Stall = stl[i];
      tick();
      n_checks += 2;
      if ({pc2, flush2} !== exp2[i]) begin n_fail++; $display("FAIL flush_seq%0d got=%h exp=%h", i, {pc2, flush2}, exp2[i]); end
      if (obs1 !== expv(m1)) begin n_fail++; $display("FAIL flush_seq%0d dut1 got=%h exp=%h", i, obs1, expv(m1)); end
      DecodePC = 32'h800;
    end
    idle(4);
    BranchAndJump = 2'd1; DecodePC = 32'h500; BranchOffset = 32'd8;
    tick();
    set_idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++;
    if ({pc1, flush1, pc2, flush2} !== {32'h0, 1'b0, 32'h0, 1'b0}) begin n_fail++; $display("FAIL reset_mid_flush got=%h exp=0", {pc1, flush1, pc2, flush2}); end
    idle(2);
  endtask

  task automatic test_wrap();
    logic [31:0] seq [4] = '{32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    set_idle();
    BranchAndJump = 2'd2; RegTarget = 32'hFFFF_FFF5;
    for (int i = 0; i < 4; i++) begin
      tick();
      set_idle();
      n_checks++;
      if ({pc1, pc2} !== {seq[i], seq[i]}) begin n_fail++; $display("FAIL wrap%0d got=%h exp=%h", i, {pc1, pc2}, {seq[i], seq[i]}); end
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      Reset         = ($urandom_range(0, 99) == 0);
      Stall         = ($urandom_range(0, 2) == 0);
      BranchAndJump = 2'($urandom_range(0, 3));
      IsJump        = 1'($urandom);
      DecodePC      = $urandom;
      BranchOffset  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(8'($urandom)));
      JumpIndex     = 26'($urandom);
      RegTarget     = $urandom;
      tick();
      n_checks += 2;
      if (obs1 !== expv(m1)) begin n_fail++; $display("FAIL random%0d dut1 got=%h exp=%h", i, obs1, expv(m1)); end
      if (obs2 !== expv(m2)) begin n_fail++; $display("FAIL random%0d dut2 got=%h exp=%h", i, obs2, expv(m2)); end
    end
    idle(3);
  endtask

  initial begin
    m1 = '0;
    m2 = '0;
    test_reset();
    test_branch();
    test_jumps();
    test_stall_redirect();
    test_flush_stall();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
